// File: rtl/full_adder_subtractor_pkg.sv
// Shared constants for the registered add/sub block.
// Mode encoding and output-flag reset bundle.
package full_adder_subtractor_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef struct packed {
    logic valid;
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  localparam flags_t FLAGS_RST = '0;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
// Chained WIDTH times to form the ripple core.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/full_adder_subtractor.sv
// Registered two's-complement add/sub with flags.
// Ripple core feeding a single output register stage.
module full_adder_subtractor
  import full_adder_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s_comb;
  flags_t           f_comb;
  flags_t           f_q;

  // Subtraction is A + ~B + 1.
  assign is_sub = (sub == MODE_SUB);
  assign b_eff  = b ^ {WIDTH{is_sub}};
  assign c[0]   = is_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (s_comb[i]),
      .cout (c[i+1])
    );
  end

  // Flags derived from the ripple carries.
  always_comb begin
    f_comb       = FLAGS_RST;
    f_comb.valid = 1'b1;
    f_comb.cout  = c[WIDTH];
    f_comb.ovf   = c[WIDTH] ^ c[WIDTH-1];
    f_comb.zero  = (s_comb == '0);
  end

  // Capture on valid, otherwise hold data and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q <= FLAGS_RST;
      s   <= '0;
    end else begin
      f_q.valid <= in_valid;
      if (in_valid) begin
        f_q.cout <= f_comb.cout;
        f_q.ovf  <= f_comb.ovf;
        f_q.zero <= f_comb.zero;
        s        <= s_comb;
      end
    end
  end

  assign out_valid = f_q.valid;
  assign cout      = f_q.cout;
  assign ovf       = f_q.ovf;
  assign zero      = f_q.zero;

endmodule

// File: tb/tb_full_adder_subtractor.sv
// Bench for full_adder_subtractor at WIDTH 1 and 8.
// Tables, directed sequences and random vs. model.
module tb_full_adder_subtractor;
  import full_adder_subtractor_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v1 = 1'b0, sub1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ov1, co1, of1, z1;
  logic [0:0] s1;

  logic       v8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, co8, of8, z8;
  logic [7:0] s8;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  full_adder_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .sub(sub1), .a(a1), .b(b1),
    .out_valid(ov1), .s(s1), .cout(co1),
    .ovf(of1), .zero(z1)
  );

  full_adder_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8),
    .sub(sub8), .a(a8), .b(b8),
    .out_valid(ov8), .s(s8), .cout(co8),
    .ovf(of8), .zero(z8)
  );

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } res_t;

  typedef struct packed {
    logic       sub;
    logic       a;
    logic       b;
    logic [1:0] cs;
  } vec1_t;

  typedef struct packed {
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
  } vec8_t;

  task automatic chk(input string nm,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  // Reference: plain integer arithmetic.
  function automatic res_t model(input logic sb,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    res_t r;
    int ua, ub, sa, sbv, u, sr;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      u    = ua - ub;
      sr   = sa - sbv;
      r.c  = (ua >= ub);
    end else begin
      u    = ua + ub;
      sr   = sa + sbv;
      r.c  = (u > 255);
    end
    r.s = u[7:0];
    r.o = (sr > 127) || (sr < -128);
    r.z = (r.s == 8'h00);
    return r;
  endfunction

  task automatic chk8(input string nm, input res_t e,
                      input logic ev);
    chk({nm, ".valid"}, 8'(ov8), 8'(ev));
    chk({nm, ".s"}, s8, e.s);
    chk({nm, ".cout"}, 8'(co8), 8'(e.c));
    chk({nm, ".ovf"}, 8'(of8), 8'(e.o));
    chk({nm, ".zero"}, 8'(z8), 8'(e.z));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec1_t t1 [8];
  vec8_t t8 [4];
  res_t  e, held;
  logic  ev;

  initial begin
    t1[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    t1[1] = '{1'b0, 1'b0, 1'b1, 2'b01};
    t1[2] = '{1'b0, 1'b1, 1'b0, 2'b01};
    t1[3] = '{1'b0, 1'b1, 1'b1, 2'b10};
    t1[4] = '{1'b1, 1'b0, 1'b0, 2'b10};
    t1[5] = '{1'b1, 1'b0, 1'b1, 2'b01};
    t1[6] = '{1'b1, 1'b1, 1'b0, 2'b11};
    t1[7] = '{1'b1, 1'b1, 1'b1, 2'b10};

    t8[0] = '{MODE_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    t8[1] = '{MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    t8[2] = '{MODE_SUB, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0};
    t8[3] = '{MODE_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst.w8", {ov8, co8, of8, z8, 4'h0}, 8'h00);
    chk("rst.s8", s8, 8'h00);
    chk("rst.w1", {4'h0, ov1, co1, of1, z1}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive sweep
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v1 = 1'b1; sub1 = t1[i].sub;
      a1 = t1[i].a; b1 = t1[i].b;
      tick();
      chk($sformatf("w1[%0d].valid", i), 8'(ov1), 8'h01);
      chk($sformatf("w1[%0d].cs", i),
          8'({co1, s1}), 8'(t1[i].cs));
    end
    @(negedge clk);
    v1 = 1'b0;

    // WIDTH=8 directed table
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v8 = 1'b1; sub8 = t8[i].sub;
      a8 = t8[i].a; b8 = t8[i].b;
      tick();
      e = '{t8[i].s, t8[i].c, t8[i].o, t8[i].z};
      chk8($sformatf("dir[%0d]", i), e, 1'b1);
    end

    // Valid gating and hold
    @(negedge clk);
    v8 = 1'b1; sub8 = MODE_ADD; a8 = 8'd3; b8 = 8'd4;
    tick();
    e = '{8'd7, 1'b0, 1'b0, 1'b0};
    chk8("hold.cap", e, 1'b1);
    @(negedge clk);
    v8 = 1'b0; a8 = 8'd9; b8 = 8'd9;
    tick();
    chk8("hold.idle", e, 1'b0);

    // Async reset between edges
    @(negedge clk);
    v8 = 1'b1; sub8 = MODE_SUB; a8 = 8'h40; b8 = 8'h10;
    tick();
    chk8("ar.pre", model(1'b1, 8'h40, 8'h10), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk8("ar.async", '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    v8 = 1'b1; sub8 = MODE_ADD; a8 = 8'h10; b8 = 8'h20;
    tick();
    chk8("ar.post", '{8'h30, 1'b0, 1'b0, 1'b0}, 1'b1);
    held = '{8'h30, 1'b0, 1'b0, 1'b0};

    // Random traffic vs. model
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      v8   = ($urandom_range(0, 3) != 0);
      sub8 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0: a8 = 8'h80;
        1: a8 = 8'h7F;
        2: a8 = 8'hFF;
        default: a8 = 8'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b8 = 8'h00;
        1: b8 = a8;
        2: b8 = 8'h01;
        default: b8 = 8'($urandom);
      endcase
      if (v8) held = model(sub8, a8, b8);
      ev = v8;
      tick();
      chk8($sformatf("rnd[%0d]", i), held, ev);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
